// File: rtl/yarp_mem_arbiter_pkg.sv
// Shared types for the YARP memory-port arbiter: FSM states, grant
// source encoding and the access-size codes used on the memory port.
package yarp_mem_arbiter_pkg;

  // Access-size codes carried on byte_en, same encodings as the core
  localparam logic [1:0] BYTE      = 2'b00;
  localparam logic [1:0] HALF_WORD = 2'b01;
  localparam logic [1:0] WORD      = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } arb_src_t;

endpackage

// File: rtl/yarp_mem_arbiter_if.sv
// Bundle of the fetch, load/store and downstream memory signals around the
// arbiter. The master modport is the arbiter's view, slave the environment's.
interface yarp_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch requester
  logic              instr_req_i;
  logic [ADDR_W-1:0] instr_addr_i;
  logic              instr_ready_o;
  logic [DATA_W-1:0] instr_rd_data_o;
  // Load/store requester
  logic              data_req_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic              data_wr_i;
  logic [1:0]        data_byte_en_i;
  logic [DATA_W-1:0] data_wr_data_i;
  logic              data_ready_o;
  logic [DATA_W-1:0] data_rd_data_o;
  // Downstream memory port
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_wr_o;
  logic [1:0]        mem_byte_en_o;
  logic [DATA_W-1:0] mem_wr_data_o;
  logic              mem_ready_i;
  logic [DATA_W-1:0] mem_rd_data_i;

  modport master (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_addr_i, data_wr_i, data_byte_en_i, data_wr_data_i,
    input  mem_ready_i, mem_rd_data_i,
    output instr_ready_o, instr_rd_data_o, data_ready_o, data_rd_data_o,
    output mem_req_o, mem_addr_o, mem_wr_o, mem_byte_en_o, mem_wr_data_o
  );

  modport slave (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_addr_i, data_wr_i, data_byte_en_i, data_wr_data_i,
    output mem_ready_i, mem_rd_data_i,
    input  instr_ready_o, instr_rd_data_o, data_ready_o, data_rd_data_o,
    input  mem_req_o, mem_addr_o, mem_wr_o, mem_byte_en_o, mem_wr_data_o
  );

endinterface

// File: rtl/yarp_mem_arbiter_pick.sv
// Combinational winner selection for the memory arbiter.
// Build option YARP_ARB_ROUND_ROBIN_EN: defined -> ties go to the requester
// that was not granted last; undefined -> data always wins a tie.
module yarp_arb_pick
  import yarp_mem_arbiter_pkg::*;
(
  input  logic     instr_req_i,
  input  logic     data_req_i,
  input  arb_src_t last_grant_i,
  output arb_src_t winner_o
);

`ifdef YARP_ARB_ROUND_ROBIN_EN
  // Single requester wins outright; a tie alternates away from the last grant
  always_comb begin
    winner_o = SRC_INSTR;
    if (instr_req_i && data_req_i) begin
      winner_o = (last_grant_i == SRC_DATA) ? SRC_INSTR : SRC_DATA;
    end else if (data_req_i) begin
      winner_o = SRC_DATA;
    end
  end
`else
  // Fixed priority never needs the history or the fetch request itself
  logic unused_pick;
  assign unused_pick = last_grant_i ^ instr_req_i;

  // Data has priority; fetch wins only when data is not requesting
  always_comb begin
    winner_o = data_req_i ? SRC_DATA : SRC_INSTR;
  end
`endif

endmodule

// File: rtl/yarp_mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch
// and load/store. Grants are registered; completion is a combinational
// pass-through of mem_ready_i. Tie policy selected by YARP_ARB_ROUND_ROBIN_EN.
module yarp_mem_arbiter
  import yarp_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                 clk,
  input logic                 reset_n,
  yarp_mem_arbiter_if.master  bus
);

  arb_state_t        state_q;
  arb_src_t          last_grant_q;
  arb_src_t          winner;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_wr_q;
  logic [1:0]        mem_byte_en_q;
  logic [DATA_W-1:0] mem_wr_data_q;
  logic              instr_done;
  logic              data_done;

  yarp_arb_pick u_pick (
    .instr_req_i  (bus.instr_req_i),
    .data_req_i   (bus.data_req_i),
    .last_grant_i (last_grant_q),
    .winner_o     (winner)
  );

  // Grant in IDLE, latch the winner's attributes, release on mem_ready_i
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_grant_q  <= SRC_INSTR;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_q      <= 1'b0;
      mem_byte_en_q <= '0;
      mem_wr_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.instr_req_i || bus.data_req_i) begin
            last_grant_q <= winner;
            mem_req_q    <= 1'b1;
            if (winner == SRC_DATA) begin
              state_q       <= BUSY_D;
              mem_addr_q    <= bus.data_addr_i;
              mem_wr_q      <= bus.data_wr_i;
              mem_byte_en_q <= bus.data_byte_en_i;
              mem_wr_data_q <= bus.data_wr_data_i;
            end else begin
              // Fetches are always full-word reads
              state_q       <= BUSY_I;
              mem_addr_q    <= bus.instr_addr_i;
              mem_wr_q      <= 1'b0;
              mem_byte_en_q <= WORD;
              mem_wr_data_q <= '0;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          // Every transfer returns through IDLE, leaving a one-cycle bubble
          if (bus.mem_ready_i) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_q      <= 1'b0;
            mem_byte_en_q <= '0;
            mem_wr_data_q <= '0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Completion only counts for the requester currently being served
  assign instr_done = (state_q == BUSY_I) && bus.mem_ready_i;
  assign data_done  = (state_q == BUSY_D) && bus.mem_ready_i;

  assign bus.instr_ready_o   = instr_done;
  assign bus.instr_rd_data_o = instr_done ? bus.mem_rd_data_i : '0;
  assign bus.data_ready_o    = data_done;
  assign bus.data_rd_data_o  = data_done ? bus.mem_rd_data_i : '0;

  assign bus.mem_req_o     = mem_req_q;
  assign bus.mem_addr_o    = mem_addr_q;
  assign bus.mem_wr_o      = mem_wr_q;
  assign bus.mem_byte_en_o = mem_byte_en_q;
  assign bus.mem_wr_data_o = mem_wr_data_q;

endmodule
